// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the fetch PC, buffers {pc, instr} pairs in a small prefetch queue
// and hands them to decode, with redirect, halt-on-ecall and out-of-range fault handling.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] HALT_INSN = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {START, RUN, HALTED, FAULT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   fetch_count_q, fetch_count_d;
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_range, enq, pop;

    assign in_range    = {2'b00, fetch_pc_q[31:2]} < 32'(MEM_WORDS);
    assign if_valid    = (count_q != '0) && !redirect_valid;
    assign pop         = if_valid && if_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign enq         = (state_q == RUN) && !redirect_valid && in_range &&
                         ((count_q < CW'(DEPTH)) || pop);
    assign imem_addr   = fetch_pc_q;
    assign if_instr    = instr_q[head_q];
    assign if_pc       = pc_q[head_q];
    assign halted      = (state_q == HALTED);
    assign fault       = (state_q == FAULT);
    assign fetch_count = fetch_count_q;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (enq) begin
            pc_d[tail_q]    = fetch_pc_q;
            instr_d[tail_q] = imem_rdata;
        end
        head_d        = redirect_valid ? '0 : head_q + PW'(pop);
        tail_d        = redirect_valid ? '0 : tail_q + PW'(enq);
        count_d       = redirect_valid ? '0 : count_q + CW'(enq) - CW'(pop);
        fetch_pc_d    = redirect_valid ? {redirect_pc[31:2], 2'b00}
                                       : fetch_pc_q + (enq ? 32'd4 : 32'd0);
        fetch_count_d = fetch_count_q + 32'(enq);
        // START only burns the cycle in which memory was still held in reset.
        state_d = redirect_valid                    ? RUN
                : (state_q == START)                ? RUN
                : (state_q != RUN)                  ? state_q
                : !in_range                         ? FAULT
                : (enq && imem_rdata == HALT_INSN)  ? HALTED
                :                                     RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= START;
            fetch_pc_q    <= RESET_PC;
            fetch_count_q <= '0;
            pc_q          <= '{default: '0};
            instr_q       <= '{default: '0};
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_count_q <= fetch_count_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: random fetch streams scored against the sequential-PC stream expected
// from memory contents; directed checks for reset, fill latency, backpressure and redirect.
module tb_imem_fetch_ctrl;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] HALT      = 32'h0000_0073;

    logic        clk, rst, if_valid, if_ready, redirect_valid, halted, fault;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, redirect_pc, fetch_count;
    logic [31:0] mem [MEM_WORDS];

    int          n_cmp, n_bad, delivered, ready_mode;
    logic        count_known, exp_halt;
    logic [31:0] exp_end;
    logic [63:0] exp_q [$];
    logic [63:0] e;

    assign imem_rdata = mem[imem_addr[11:2]];

    imem_fetch_ctrl #(
        .RESET_PC(32'h0), .DEPTH(2), .MEM_WORDS(MEM_WORDS), .HALT_INSN(HALT)
    ) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .fault(fault), .fetch_count(fetch_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic void fill_mem(int halt_idx);
        for (int i = 0; i < MEM_WORDS; i++) begin
            logic [31:0] w = $urandom;
            mem[i] = (w == HALT) ? ~w : w;
        end
        if (halt_idx >= 0 && halt_idx < MEM_WORDS) mem[halt_idx] = HALT;
    endfunction

    // Expected delivery: consecutive words from the start PC until HALT (inclusive) or end of memory.
    function automatic void build_stream(logic [31:0] start);
        logic [31:0] pc = {start[31:2], 2'b00};
        exp_q.delete();
        exp_halt = 1'b0;
        while (32'(pc[31:2]) < 32'(MEM_WORDS)) begin
            exp_q.push_back({pc, mem[pc[11:2]]});
            pc += 4;
            if (mem[pc[11:2] - 10'd1] == HALT) begin
                exp_halt = 1'b1;
                break;
            end
        end
        exp_end = pc;
    endfunction

    always @(negedge clk) begin
        if (rst && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_delivery got_pc=%h exp=none @%0t", if_pc, $time);
            end else begin
                e = exp_q.pop_front();
                chk("deliv_pc", if_pc, e[63:32]);
                chk("deliv_instr", if_instr, e[31:0]);
                delivered++;
            end
        end
    end

    initial begin
        if_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
        end
    end

    task automatic reset_assert(int halt_idx);
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_addr", imem_addr, 0);
        fill_mem(halt_idx);
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b1;
        build_stream(32'h0);
        delivered   = 0;
        count_known = 1'b1;
    endtask

    task automatic do_redirect(logic [31:0] pc, int halt_idx);
        @(posedge clk);
        #1;
        fill_mem(halt_idx);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        build_stream(pc);
        @(negedge clk);
        chk("redir_valid", 32'(if_valid), 0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        chk("redir_addr", imem_addr, {pc[31:2], 2'b00});
        chk("redir_halted", 32'(halted), 0);
        chk("redir_fault", 32'(fault), 0);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 0);
        repeat (4) @(negedge clk);
        chk("end_valid", 32'(if_valid), 0);
        chk("end_halted", 32'(halted), 32'(exp_halt));
        chk("end_fault", 32'(fault), 32'(!exp_halt));
        chk("end_addr", imem_addr, exp_end);
        if (count_known) chk("fetch_count", fetch_count, 32'(delivered));
    endtask

    initial begin
        int si;
        n_cmp = 0;
        n_bad = 0;
        delivered = 0;
        ready_mode = 1;
        count_known = 1'b1;
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        fill_mem(-1);

        reset_assert(4);
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        reset_release();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) chk("start_valid", 32'(if_valid), 0);
            else begin
                chk("tp_valid", 32'(if_valid), 1);
                chk("tp_pc", if_pc, 32'((k - 2) * 4));
                chk("tp_count", fetch_count, 32'(k - 1));
            end
        end
        wait_drain();

        ready_mode = 0;
        reset_assert(10);
        reset_release();
        repeat (6) @(negedge clk);
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_valid", 32'(if_valid), 1);
        chk("bp_pc", if_pc, 32'h0);
        chk("bp_count", fetch_count, 32'd2);
        count_known = 1'b0;
        do_redirect(32'h103, 32'h43);
        ready_mode = 2;
        wait_drain();

        reset_assert($urandom_range(0, 8));
        reset_release();
        wait_drain();
        for (int s = 0; s < 10; s++) begin
            case ($urandom_range(0, 2))
                0: begin
                    si = $urandom_range(0, MEM_WORDS - 32);
                    do_redirect(32'(si * 4 + $urandom_range(0, 3)), si + $urandom_range(0, 20));
                end
                1: begin
                    si = MEM_WORDS - $urandom_range(1, 16);
                    do_redirect(32'(si * 4 + $urandom_range(0, 3)), -1);
                end
                default: do_redirect(32'h1000 + 32'($urandom_range(0, 255) * 4), -1);
            endcase
            wait_drain();
        end

        count_known = 1'b0;
        for (int s = 0; s < 12; s++) begin
            si = $urandom_range(0, MEM_WORDS - 1);
            do_redirect(32'(si * 4), si + $urandom_range(0, 40));
            repeat ($urandom_range(0, 25)) @(posedge clk);
        end
        do_redirect(32'(MEM_WORDS * 4 - 24), -1);
        wait_drain();

        do_redirect(32'h200, 32'h80 + 40);
        repeat (10) @(posedge clk);
        reset_assert($urandom_range(2, 12));
        reset_release();
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
